fetch_unit: RTL and testbench

Instruction fetch stage feeding the decode stage and closing the control loop with the execute stage. It holds the architectural PC and issues one-outstanding word fetches to instruction memory over a req/gnt/rvalid handshake. It hands fetched instructions to decode through a 2-entry output buffer with valid/stall flow control. When the execute stage reports a taken branch (`br_taken_i`, `new_pc_i`), it flushes the buffer, discards wrong-path responses and restarts fetching at the target.

---
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch feeding decode through a 2-entry buffer.
// Optional misaligned-redirect trap is compiled in with FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        br_taken_i,
  input  logic [31:0] new_pc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HALT} state_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam entry_t ENTRY_RST = {1'b0, 32'h0000_0000, NOP};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fpc_q, fpc_d;
  entry_t      out_q, out_d;
  entry_t      skid_q, skid_d;
  logic        mis_q, mis_d;
  logic        halt_pend_q, halt_pend_d;

  logic        req, granted, resp, consume, redir, busy_after, tgt_misaligned;
  logic [31:0] tgt_pc;

  // A request is only offered while the skid is free, so every response has a slot.
  assign req        = (state_q == REQ) && !skid_q.vld;
  assign granted    = req && imem_gnt_i;
  assign resp       = (state_q == WAIT) && imem_rvalid_i;
  assign consume    = out_q.vld && !stall_i;
  assign redir      = br_taken_i && (state_q != HALT) && !mis_q;
  assign busy_after = granted || (((state_q == WAIT) || (state_q == DROP)) && !imem_rvalid_i);
  assign tgt_pc     = {new_pc_i[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt_misaligned = (new_pc_i[1:0] != 2'b00);
`else
  logic unused_tgt_lsb;
  assign tgt_misaligned = 1'b0;
  assign unused_tgt_lsb = ^new_pc_i[1:0];
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fpc_d       = fpc_q;
    out_d       = out_q;
    skid_d      = skid_q;
    mis_d       = mis_q;
    halt_pend_d = halt_pend_q;

    if (consume) begin
      if (skid_q.vld) begin
        out_d      = skid_q;
        skid_d.vld = 1'b0;
      end else begin
        out_d.vld = 1'b0;
      end
    end

    if (resp) begin
      if (!out_q.vld || consume) out_d  = '{vld: 1'b1, pc: fpc_q, instr: imem_rdata_i};
      else                       skid_d = '{vld: 1'b1, pc: fpc_q, instr: imem_rdata_i};
    end

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (granted) begin
          fpc_d   = pc_q;
          pc_d    = pc_q + 32'd4;
          state_d = WAIT;
        end
      end
      WAIT: if (imem_rvalid_i) state_d = REQ;
      DROP: if (imem_rvalid_i) state_d = halt_pend_q ? HALT : REQ;
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above; a same-cycle response is wrong-path.
    if (redir) begin
      out_d.vld  = 1'b0;
      skid_d.vld = 1'b0;
      pc_d       = tgt_pc;
      state_d    = busy_after ? DROP : REQ;
      if (tgt_misaligned) begin
        mis_d       = 1'b1;
        halt_pend_d = busy_after;
        if (!busy_after) state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      fpc_q       <= RESET_PC;
      out_q       <= ENTRY_RST;
      skid_q      <= ENTRY_RST;
      mis_q       <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fpc_q       <= fpc_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      mis_q       <= mis_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign valid_o     = out_q.vld;
  assign instr_o     = out_q.instr;
  assign pc_o        = out_q.pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

  a_addr_aligned: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    imem_req_o |-> (imem_addr_o[1:0] == 2'b00));
  a_skid_behind_out: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    skid_q.vld |-> out_q.vld);
  a_halt_quiet: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (state_q == HALT) |-> (!out_q.vld && !imem_req_o));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reactive imem model, in-order delivery model, literal timing checks.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] new_pc   = 32'h0;
  logic        stall    = 1'b0;
  logic        gnt      = 1'b0;
  logic        rvalid   = 1'b0;
  logic [31:0] rdata    = 32'h0;
  logic        req, valid, misalign;
  logic [31:0] addr, instr, pc;

  fetch_unit u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .br_taken_i(br_taken), .new_pc_i(new_pc),
    .stall_i(stall), .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .valid_o(valid),
    .instr_o(instr), .pc_o(pc), .misalign_o(misalign)
  );

  // Second instance only exercises the PC wrap from the top of the address space.
  logic        w_req;
  logic        w_rvalid = 1'b0;
  logic        w_fire   = 1'b0;
  logic [31:0] w_addr;
  logic        unused_w_valid, unused_w_mis;
  logic [31:0] unused_w_instr, unused_w_pc;
  logic [31:0] w_addrs [$];

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .br_taken_i(1'b0), .new_pc_i(32'h0),
    .stall_i(1'b0), .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(1'b1),
    .imem_rvalid_i(w_rvalid), .imem_rdata_i(32'h0000_0013), .valid_o(unused_w_valid),
    .instr_o(unused_w_instr), .pc_o(unused_w_pc), .misalign_o(unused_w_mis)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0BAD_F00D;
  endfunction

  // Instruction memory: grants per mode, answers after 1..k_max cycles.
  bit          rand_gnt = 1'b0;
  int          k_max    = 1;
  bit          mem_busy = 1'b0, fire_pend = 1'b0, prev_pend = 1'b0, prev_br = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0, fire_addr = 32'h0, prev_addr = 32'h0;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      mem_busy = 1'b0; fire_pend = 1'b0; prev_pend = 1'b0; prev_br = 1'b0;
      rvalid = 1'b0; gnt = 1'b0;
    end else begin
      if (prev_pend && req && !prev_br) chk("addr stable", addr, prev_addr);
      if (fire_pend) begin
        mem_busy = 1'b1; mem_addr = fire_addr; mem_cnt = int'($urandom_range(1, k_max));
      end
      rvalid = 1'b0;
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          rvalid = 1'b1; rdata = memf(mem_addr); mem_busy = 1'b0;
        end else mem_cnt--;
      end
      gnt       = rand_gnt ? ($urandom_range(0, 9) < 7) : 1'b1;
      fire_pend = gnt && req;
      fire_addr = addr;
      if (fire_pend) chk("single outstanding", 32'(mem_busy), 32'd0);
      prev_pend = req && !gnt;
      prev_addr = addr;
      prev_br   = br_taken;
    end
  end

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      w_fire = 1'b0; w_rvalid = 1'b0;
    end else begin
      w_rvalid = w_fire;
      w_fire   = w_req;
      if (w_fire) w_addrs.push_back(w_addr);
    end
  end

  // Delivery model: decode must see the architectural stream in order, restarting at each target.
  logic [31:0] exp_pc = 32'h0;
  bit          halted = 1'b0, redir_last = 1'b0;
  int          delivered = 0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      exp_pc = 32'h0; halted = 1'b0; redir_last = 1'b0;
    end else begin
      if (redir_last || halted) chk("valid low", 32'(valid), 32'd0);
      chk("misalign_o", 32'(misalign), 32'(halted));
      if (halted) chk("no req in halt", 32'(req), 32'd0);
      if (valid) begin
        chk("pc_o", pc, exp_pc);
        chk("instr_o", instr, memf(exp_pc));
        if (!stall) begin
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
      end
      redir_last = 1'b0;
      if (br_taken && !halted) begin
        redir_last = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (new_pc[1:0] != 2'b00) halted = 1'b1;
`endif
        exp_pc = {new_pc[31:2], 2'b00};
      end
    end
  end

  bit t1_req [7] = '{1, 0, 1, 0, 1, 0, 1};
  bit t1_val [7] = '{0, 0, 1, 0, 1, 0, 1};
  bit t2_req [10] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
  bit t2_val [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; br_taken = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst req", 32'(req), 32'd0);
    chk("rst addr", addr, 32'h0);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst instr", instr, 32'h0000_0013);
    chk("rst pc", pc, 32'h0);
    chk("rst misalign", 32'(misalign), 32'd0);

    // Back-to-back fetch, immediate grant, 1-cycle response.
    @(negedge clk); rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk); #3;
      chk("t1 req", 32'(req), 32'(t1_req[i-1]));
      chk("t1 valid", 32'(valid), 32'(t1_val[i-1]));
      if (t1_req[i-1]) chk("t1 addr", addr, 32'((i - 1) * 2));
      if (t1_val[i-1]) chk("t1 pc", pc, 32'((i - 3) * 2));
    end
    chk("wrap fires", 32'(w_addrs.size() >= 2), 32'd1);
    if (w_addrs.size() >= 2) begin
      chk("wrap addr0", w_addrs[0], 32'hFFFF_FFFC);
      chk("wrap addr1", w_addrs[1], 32'h0000_0000);
    end

    // Stall/skid, redirect on grant, redirect on response, misaligned redirect.
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      br_taken = 1'b0;
      stall = (i >= 2 && i <= 7) || i == 13 || i == 14;
      if (i == 9)  begin br_taken = 1'b1; new_pc = 32'h100; end
      if (i == 14) begin br_taken = 1'b1; new_pc = 32'h200; end
      if (i == 17) begin br_taken = 1'b1; new_pc = 32'h102; end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (i == 20) begin br_taken = 1'b1; new_pc = 32'h300; end
`endif
      #3;
      if (i <= 10) begin
        chk("t2 req", 32'(req), 32'(t2_req[i-1]));
        chk("t2 valid", 32'(valid), 32'(t2_val[i-1]));
      end
      if (i >= 3 && i <= 8) chk("stall hold pc", pc, 32'h0);
      if (i == 3) chk("addr 0x4", addr, 32'h4);
      if (i == 9) begin chk("skid pc", pc, 32'h4); chk("addr 0x8", addr, 32'h8); end
      if (i == 11) begin chk("redir req", 32'(req), 32'd1); chk("redir addr", addr, 32'h100); end
      if (i == 13) begin chk("target valid", 32'(valid), 32'd1); chk("target pc", pc, 32'h100); end
      if (i == 15) begin
        chk("drop valid", 32'(valid), 32'd0);
        chk("drop req", 32'(req), 32'd1);
        chk("drop addr", addr, 32'h200);
      end
      if (i == 17) chk("target2 pc", pc, 32'h200);
`ifdef FETCH_MISALIGN_TRAP_EN
      if (i >= 18) begin
        chk("trap misalign", 32'(misalign), 32'd1);
        chk("trap req", 32'(req), 32'd0);
        chk("trap valid", 32'(valid), 32'd0);
      end
`else
      if (i == 18) chk("no trap", 32'(misalign), 32'd0);
      if (i == 19) begin chk("force align req", 32'(req), 32'd1); chk("force align addr", addr, 32'h100); end
      if (i == 21) begin chk("aligned valid", 32'(valid), 32'd1); chk("aligned pc", pc, 32'h100); end
`endif
    end

    // Asynchronous reset must clear state without a clock edge.
    @(negedge clk);
    rst_n = 1'b0; br_taken = 1'b0; stall = 1'b0;
    #1;
    chk("async addr", addr, 32'h0);
    chk("async valid", 32'(valid), 32'd0);
    chk("async misalign", 32'(misalign), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Mixed grant delays, latencies, stalls and aligned redirects.
    rand_gnt = 1'b1; k_max = 3; d0 = delivered;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      stall    = ($urandom_range(0, 9) < 3);
      br_taken = ($urandom_range(0, 19) == 0);
      new_pc   = 32'($urandom_range(0, 1023) << 2);
    end
    @(negedge clk); br_taken = 1'b0; stall = 1'b0;
    chk("progress", 32'((delivered - d0) >= 15), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
